// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared widths, pointer sizes and entry type for store_buffer
package store_buffer_pkg;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;
endpackage

// File: rtl/sb_match.sv
// rtl/sb_match.sv - youngest-first address match over the buffered stores
module sb_match
  import store_buffer_pkg::*;
(
  input  sb_entry_t         entries [DEPTH],
  input  logic [DEPTH-1:0]  valid,
  input  logic [PTR_W-1:0]  rd_ptr,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data
);
  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (valid[idx] && entries[idx].addr == ld_addr) begin
        hit      = 1'b1;
        hit_data = entries[idx].data;
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write store buffer in front of the data memory
// STORE_BUF_FWD_EN: forward loads from buffered stores; otherwise stall and drain on a match.
module store_buffer
  import store_buffer_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_stall,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              empty
);
  sb_entry_t        entries_q [DEPTH];
  sb_entry_t        entries_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic              push;
  logic              pop;
  logic              hit;
  logic [DATA_W-1:0] hit_data;
  logic [DEPTH-1:0]  valid;
  logic [PTR_W-1:0]  off;
  sb_entry_t         head;

  assign empty    = (count_q == '0);
  assign st_ready = (count_q != CNT_W'(DEPTH));
  assign push     = st_valid && st_ready;
  assign head     = entries_q[rd_ptr_q];

  // An entry is live when its distance from the head is below the fill count.
  always_comb begin
    valid = '0;
    off   = '0;
    for (int j = 0; j < DEPTH; j++) begin
      off      = PTR_W'(j) - rd_ptr_q;
      valid[j] = ({1'b0, off} < count_q);
    end
  end

  sb_match u_match (
    .entries  (entries_q),
    .valid    (valid),
    .rd_ptr   (rd_ptr_q),
    .ld_addr  (ld_addr),
    .hit      (hit),
    .hit_data (hit_data)
  );

  always_comb begin
    pop         = 1'b0;
    mem_read    = 1'b0;
    mem_address = empty ? '0 : head.addr;
    mem_data    = empty ? '0 : head.data;
    ld_data     = mem_rdata;
    ld_stall    = 1'b0;
`ifdef STORE_BUF_FWD_EN
    pop      = !empty && !ld_req;
    mem_read = ld_req;
    if (ld_req) mem_address = ld_addr;
    if (ld_req && hit) ld_data = hit_data;
`else
    // A matching load waits while the drain runs, so memory ends up holding the youngest data.
    ld_stall = ld_req && hit;
    pop      = !empty && (!ld_req || hit);
    mem_read = ld_req && !hit;
    if (mem_read) mem_address = ld_addr;
    if (ld_stall) ld_data = hit_data;
`endif
    mem_write = pop;
  end

  always_comb begin
    entries_d = entries_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push) begin
      entries_d[wr_ptr_q] = '{addr: st_addr, data: st_data};
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    entries_q <= entries_d;
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed vector bench for store_buffer with a behavioural memory
module tb_store_buffer;
  logic       clock = 1'b0;
  logic       reset;
  logic       st_valid, st_ready;
  logic [7:0] st_addr, st_data;
  logic       ld_req;
  logic [7:0] ld_addr, ld_data;
  logic       ld_stall, mem_write, mem_read;
  logic [7:0] mem_address, mem_data, mem_rdata;
  logic       empty;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] mem [256];

  always #5 clock = ~clock;

  always @(posedge clock) if (mem_write) mem[mem_address] <= mem_data;
  assign mem_rdata = mem[mem_address];

  store_buffer dut (
    .clock       (clock),
    .reset       (reset),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .ld_req      (ld_req),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_stall    (ld_stall),
    .mem_write   (mem_write),
    .mem_read    (mem_read),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_rdata   (mem_rdata),
    .empty       (empty)
  );

  typedef struct {
    logic       sv;
    logic [7:0] sa, sd;
    logic       lr;
    logic [7:0] la;
    logic       e_ready, e_empty, e_mw, e_mr;
    logic [7:0] e_addr;
    logic       c_md;
    logic [7:0] e_md;
    logic       c_ld;
    logic [7:0] e_ld;
    logic       e_stall;
  } vec_t;

  function automatic vec_t mk(logic sv, logic [7:0] sa, logic [7:0] sd, logic lr, logic [7:0] la,
                              logic er, logic ee, logic emw, logic emr, logic [7:0] ea,
                              logic cmd, logic [7:0] emd, logic cld, logic [7:0] eld, logic est);
    vec_t v;
    v.sv = sv; v.sa = sa; v.sd = sd; v.lr = lr; v.la = la;
    v.e_ready = er; v.e_empty = ee; v.e_mw = emw; v.e_mr = emr; v.e_addr = ea;
    v.c_md = cmd; v.e_md = emd; v.c_ld = cld; v.e_ld = eld; v.e_stall = est;
    return v;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    st_valid = v.sv; st_addr = v.sa; st_data = v.sd;
    ld_req   = v.lr; ld_addr = v.la;
  endtask

  task automatic check_vec(string tag, vec_t v);
    chk({tag, ".st_ready"},  {7'd0, st_ready},  {7'd0, v.e_ready});
    chk({tag, ".empty"},     {7'd0, empty},     {7'd0, v.e_empty});
    chk({tag, ".mem_write"}, {7'd0, mem_write}, {7'd0, v.e_mw});
    chk({tag, ".mem_read"},  {7'd0, mem_read},  {7'd0, v.e_mr});
    chk({tag, ".mem_addr"},  mem_address,       v.e_addr);
    chk({tag, ".ld_stall"},  {7'd0, ld_stall},  {7'd0, v.e_stall});
    if (v.c_md) chk({tag, ".mem_data"}, mem_data, v.e_md);
    if (v.c_ld) chk({tag, ".ld_data"},  ld_data,  v.e_ld);
  endtask

  task automatic cyc(string tag, vec_t v);
    drive(v);
    @(negedge clock);
    check_vec(tag, v);
    @(posedge clock);
    #1;
  endtask

  vec_t tbl [18];
  vec_t idle;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle = mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0);
    // basic drain, fill-while-loading then in-order drain, load miss with drain stalled
    tbl[0]  = idle;
    tbl[1]  = mk(1, 8'h10, 8'hAA, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0);
    tbl[2]  = mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 1, 0, 8'h10, 1, 8'hAA, 0, 8'h00, 0);
    tbl[3]  = idle;
    tbl[4]  = mk(1, 8'h01, 8'hA1, 1, 8'h80, 1, 1, 0, 1, 8'h80, 0, 8'h00, 1, 8'h77, 0);
    tbl[5]  = mk(1, 8'h02, 8'hA2, 1, 8'h80, 1, 0, 0, 1, 8'h80, 1, 8'hA1, 1, 8'h77, 0);
    tbl[6]  = mk(1, 8'h03, 8'hA3, 1, 8'h80, 1, 0, 0, 1, 8'h80, 1, 8'hA1, 1, 8'h77, 0);
    tbl[7]  = mk(1, 8'h04, 8'hA4, 1, 8'h80, 1, 0, 0, 1, 8'h80, 1, 8'hA1, 1, 8'h77, 0);
    tbl[8]  = mk(1, 8'h05, 8'hA5, 1, 8'h80, 0, 0, 0, 1, 8'h80, 1, 8'hA1, 1, 8'h77, 0);
    tbl[9]  = mk(1, 8'h05, 8'hA5, 0, 8'h00, 0, 0, 1, 0, 8'h01, 1, 8'hA1, 0, 8'h00, 0);
    tbl[10] = mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 1, 0, 8'h02, 1, 8'hA2, 0, 8'h00, 0);
    tbl[11] = mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 1, 0, 8'h03, 1, 8'hA3, 0, 8'h00, 0);
    tbl[12] = mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 1, 0, 8'h04, 1, 8'hA4, 0, 8'h00, 0);
    tbl[13] = idle;
    tbl[14] = mk(1, 8'h40, 8'h99, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0);
    tbl[15] = mk(0, 8'h00, 8'h00, 1, 8'h30, 1, 0, 0, 1, 8'h30, 1, 8'h99, 1, 8'h5C, 0);
    tbl[16] = mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 1, 0, 8'h40, 1, 8'h99, 0, 8'h00, 0);
    tbl[17] = idle;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h30] = 8'h5C;
    mem[8'h80] = 8'h77;

    reset = 1'b1;
    drive(idle);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_vec("reset", idle);
    @(posedge clock);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 18; i++) cyc($sformatf("tbl%0d", i), tbl[i]);
    chk("mem10", mem[8'h10], 8'hAA);
    chk("mem01", mem[8'h01], 8'hA1);
    chk("mem04", mem[8'h04], 8'hA4);
    chk("mem05", mem[8'h05], 8'h00);
    chk("mem40", mem[8'h40], 8'h99);

    // two stores to one address, then a load of it
    cyc("fw1", mk(1, 8'h20, 8'h11, 1, 8'h80, 1, 1, 0, 1, 8'h80, 0, 8'h00, 1, 8'h77, 0));
    cyc("fw2", mk(1, 8'h20, 8'h22, 1, 8'h80, 1, 0, 0, 1, 8'h80, 1, 8'h11, 1, 8'h77, 0));
`ifdef STORE_BUF_FWD_EN
    cyc("fw3", mk(0, 8'h00, 8'h00, 1, 8'h20, 1, 0, 0, 1, 8'h20, 1, 8'h11, 1, 8'h22, 0));
    cyc("fw4", mk(0, 8'h00, 8'h00, 1, 8'h20, 1, 0, 0, 1, 8'h20, 1, 8'h11, 1, 8'h22, 0));
    cyc("fw5", mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 1, 0, 8'h20, 1, 8'h11, 0, 8'h00, 0));
    cyc("fw6", mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 1, 0, 8'h20, 1, 8'h22, 0, 8'h00, 0));
`else
    cyc("fw3", mk(0, 8'h00, 8'h00, 1, 8'h20, 1, 0, 1, 0, 8'h20, 1, 8'h11, 0, 8'h00, 1));
    cyc("fw4", mk(0, 8'h00, 8'h00, 1, 8'h20, 1, 0, 1, 0, 8'h20, 1, 8'h22, 0, 8'h00, 1));
    cyc("fw5", mk(0, 8'h00, 8'h00, 1, 8'h20, 1, 1, 0, 1, 8'h20, 0, 8'h00, 1, 8'h22, 0));
`endif
    cyc("fw7", idle);
    chk("mem20", mem[8'h20], 8'h22);

    // a store pushed alongside a load of the same address stays invisible to that load
    cyc("sm1", mk(1, 8'h50, 8'h33, 1, 8'h50, 1, 1, 0, 1, 8'h50, 0, 8'h00, 1, 8'h00, 0));
    cyc("sm2", mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 1, 0, 8'h50, 1, 8'h33, 0, 8'h00, 0));
    cyc("sm3", mk(0, 8'h00, 8'h00, 1, 8'h50, 1, 1, 0, 1, 8'h50, 0, 8'h00, 1, 8'h33, 0));

    // fill, then push and drain together, then reset with stores still pending
    cyc("rf1", mk(1, 8'h61, 8'hB1, 1, 8'h80, 1, 1, 0, 1, 8'h80, 0, 8'h00, 1, 8'h77, 0));
    cyc("rf2", mk(1, 8'h62, 8'hB2, 1, 8'h80, 1, 0, 0, 1, 8'h80, 1, 8'hB1, 1, 8'h77, 0));
    cyc("rf3", mk(1, 8'h63, 8'hB3, 1, 8'h80, 1, 0, 0, 1, 8'h80, 1, 8'hB1, 1, 8'h77, 0));
    cyc("rf4", mk(1, 8'h64, 8'hB4, 1, 8'h80, 1, 0, 0, 1, 8'h80, 1, 8'hB1, 1, 8'h77, 0));
    cyc("rf5", mk(1, 8'h65, 8'hB5, 0, 8'h00, 0, 0, 1, 0, 8'h61, 1, 8'hB1, 0, 8'h00, 0));
    cyc("rf6", mk(1, 8'h65, 8'hB5, 0, 8'h00, 1, 0, 1, 0, 8'h62, 1, 8'hB2, 0, 8'h00, 0));
    cyc("rf7", mk(1, 8'h66, 8'hB6, 0, 8'h00, 1, 0, 1, 0, 8'h63, 1, 8'hB3, 0, 8'h00, 0));
    cyc("rf8", mk(1, 8'h67, 8'hB7, 0, 8'h00, 1, 0, 1, 0, 8'h64, 1, 8'hB4, 0, 8'h00, 0));
    drive(idle);
    @(negedge clock);
    check_vec("rf9", mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 1, 0, 8'h65, 1, 8'hB5, 0, 8'h00, 0));
    #1 reset = 1'b1;
    #1;
    check_vec("rst_async", idle);
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cyc($sformatf("post%0d", i), idle);
    chk("mem61", mem[8'h61], 8'hB1);
    chk("mem64", mem[8'h64], 8'hB4);
    chk("mem66", mem[8'h66], 8'h00);
    chk("mem67", mem[8'h67], 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
